regfile_wb_sched: RTL
=====================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 Parameter DATA_W, default 32: data width of the register-file write port.
REQ-002 Parameter ADDR_W, default 5: register address width; register count is 2**ADDR_W.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / ADDR_W / DATA_W  ALU write-back request.
REQ-006 alu_ready  output  1  ALU request accepted this cycle.
REQ-007 lsu_valid / lsu_rd / lsu_data  input  1 / ADDR_W / DATA_W  load-unit write-back request.
REQ-008 lsu_ready  output  1  LSU request accepted this cycle.
REQ-009 issue_valid / issue_rd  input  1 / ADDR_W  marks issue_rd as having a write-back pending.
REQ-010 rs1 / rs2  input  ADDR_W each  source registers to check for hazards.
REQ-011 rs1_busy / rs2_busy  output  1 each  source has an outstanding write-back.
REQ-012 rf_we / rf_waddr / rf_wdata  output  1 / ADDR_W / DATA_W  registered write port to the register file.

Function
REQ-013 Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
REQ-014 Handshake: a requester holding valid=1 keeps rd and data stable until accepted.
REQ-015 Handshake: ready is combinational from the valid inputs and arbiter state.
REQ-016 Handshake: ready is 1 only for the single granted requester, and only while its valid is 1.
REQ-017 Arbitration: at most one grant per cycle.
REQ-018 Arbitration: a lone valid requester is granted in the same cycle.
REQ-019 Arbitration: simultaneous requests are resolved per REQ-032/REQ-033.
REQ-020 Latency: an accepted request drives rf_we=1 with its rd and data on the edge after acceptance.
REQ-021 Latency: with no acceptance, rf_we=0 next cycle; rf_waddr and rf_wdata hold their last values.
REQ-022 Throughput: one write-back per cycle sustained, no bubbles while any valid is 1.
REQ-023 x0 writes: a request with rd=0 is accepted normally.
REQ-024 x0 writes: rd=0 leaves rf_we=0 and never changes the scoreboard.
REQ-025 Scoreboard: one busy bit per register; issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
REQ-026 Scoreboard: an accepted write-back clears busy[rd] at the clock edge of acceptance.
REQ-027 Scoreboard: set and clear of the same register on the same edge leaves it set (new producer wins).
REQ-028 Scoreboard: setting an already-busy register leaves it busy (single bit, no count).
REQ-029 Hazard: rsN_busy = busy[rsN] AND rsN!=0, combinational.
REQ-030 Hazard: rsN_busy reflects register state only, not writes accepted in the current cycle.
REQ-031 Hazard: busy[0] is always 0.

Configuration
REQ-032 With macro WB_RR_ARB_EN defined, contention uses round-robin.
REQ-033 With WB_RR_ARB_EN defined: a 1-bit priority pointer selects the winner; after each contended grant it points at the loser.
REQ-034 With WB_RR_ARB_EN defined: uncontended grants leave the pointer unchanged.
REQ-035 Without WB_RR_ARB_EN, LSU has fixed priority over ALU and no pointer state exists.

Reset
REQ-036 While rst=0: rf_we=0, rf_waddr=0, rf_wdata=0, all busy bits 0, priority pointer = ALU, alu_ready=0, lsu_ready=0.
REQ-037 Reset mid-operation: any write pending on the output register is dropped; no rf_we pulse follows reset release.
REQ-038 First grant is possible on the first rising edge after rst returns to 1.

Verification
REQ-039 ALU only, rd=7, data=0xDEADBEEF, accepted at edge N -> alu_ready=1 in cycle N; at edge N+1 rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF.
REQ-040 Both valid for 4 cycles, ALU rd=3, LSU rd=4, with WB_RR_ARB_EN -> grant order ALU,LSU,ALU,LSU; without it -> LSU granted every cycle, ALU stalls with alu_ready=0.
REQ-041 issue_valid with issue_rd=5, then rs1=5 -> rs1_busy=1; LSU writes rd=5 -> rs1_busy=0 after the acceptance edge.
REQ-042 Same edge: issue_rd=9 and accepted ALU write rd=9 -> busy[9]=1 afterwards.
REQ-043 ALU request rd=0, data=0x1234 -> alu_ready=1, rf_we stays 0; rs1=0 -> rs1_busy=0 even after issue_rd=0.
REQ-044 Accepted request, then rst=0 asserted asynchronously before the next edge -> rf_we=0 immediately; no write after release; all rsN_busy=0.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Write-back arbiter (ALU/LSU), registered RF write port and busy scoreboard.
// Define WB_RR_ARB_EN for round-robin contention; default is fixed LSU priority.
module regfile_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int NREG = 2 ** ADDR_W;

  logic              alu_gnt;
  logic              lsu_gnt;
  logic              acc;
  logic [ADDR_W-1:0] acc_rd;
  logic [DATA_W-1:0] acc_data;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

`ifdef WB_RR_ARB_EN
  // ptr: 0 favours ALU, 1 favours LSU; flips to the loser on contention
  logic both;
  logic ptr;

  assign both = alu_valid & lsu_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (both) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rst) begin
      if (both) begin
        alu_gnt = ~ptr;
        lsu_gnt = ptr;
      end else begin
        alu_gnt = alu_valid;
        lsu_gnt = lsu_valid;
      end
    end
  end
`else
  always_comb begin
    lsu_gnt = rst & lsu_valid;
    alu_gnt = rst & alu_valid & ~lsu_valid;
  end
`endif

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign acc       = alu_gnt | lsu_gnt;

  always_comb begin
    acc_rd   = '0;
    acc_data = '0;
    unique case (1'b1)
      lsu_gnt: begin
        acc_rd   = lsu_rd;
        acc_data = lsu_data;
      end
      alu_gnt: begin
        acc_rd   = alu_rd;
        acc_data = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= acc && (acc_rd != '0);
      if (acc) begin
        rf_waddr <= acc_rd;
        rf_wdata <= acc_data;
      end
    end
  end

  // set after clear so a new producer wins over a same-edge write-back
  always_comb begin
    busy_nxt = busy;
    if (acc) begin
      busy_nxt[acc_rd] = 1'b0;
    end
    if (issue_valid) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = busy[rs1] & (rs1 != '0);
  assign rs2_busy = busy[rs2] & (rs2 != '0);

endmodule
